// File: rtl/cs_pkg.sv
// Shared definitions for the microcode sequencer: address modes, FSM states
// and the control store address width.
package cs_pkg;

  localparam int UADDR_W = 19;

  localparam logic [1:0] MODE_EXEC  = 2'b00;
  localparam logic [1:0] MODE_IRQ   = 2'b01;
  localparam logic [1:0] MODE_FAULT = 2'b10;
  localparam logic [1:0] MODE_RESET = 2'b11;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_SETTLE,
    ST_LATCH,
    ST_HALT,
    ST_FAULT
  } ucs_state_t;

endpackage

// File: rtl/ucs_waitcnt.sv
// Loadable down-counter with a zero flag, used to wait out control store
// access time after each address change.
module ucs_waitcnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load takes priority; decrement stops at zero so the flag stays asserted.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: builds the control store address, waits out ROM access
// time, strobes the control vector register and handles halt/step and the
// microprogram counter overflow fault. The address layout is
// {mode, cond_r, opcode_r, upc}, which fills 19 bits with the default
// 5-bit microprogram counter.
module microcode_sequencer
  import cs_pkg::*;
#(
  parameter int ROM_WAIT = 3,
  parameter int UPC_BITS = 5
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [10:0]         opcode,
  input  logic                cond,
  input  logic                irq,
  input  logic                uend,
  input  logic                nhalt,
  input  logic                step,
  output logic [UADDR_W-1:0]  uaddr,
  output logic                uce,
  output logic                ucs_noe,
  output logic                halted,
  output logic [UPC_BITS-1:0] upc
);

  localparam int         WAIT_W    = 4;
  localparam logic [3:0] WAIT_LOAD = 4'(ROM_WAIT - 1);

  ucs_state_t          state_q;
  ucs_state_t          state_d;
  logic [1:0]          mode_r;
  logic                cond_r;
  logic [10:0]         opcode_r;
  logic [UPC_BITS-1:0] upc_r;
  logic                noe_r;
  logic                wait_load;
  logic                wait_dec;
  logic                wait_zero;
  logic                upc_full;

  assign upc_full = (upc_r == '1);

  ucs_waitcnt #(
    .WIDTH(WAIT_W)
  ) u_waitcnt (
    .clk     (clk),
    .nreset  (nreset),
    .load    (wait_load),
    .load_val(WAIT_LOAD),
    .dec     (wait_dec),
    .zero    (wait_zero)
  );

  // State register; reset parks the machine in RESET.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus strobes; an overflowing upc diverts through FAULT.
  always_comb begin
    state_d = state_q;
    uce     = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_RESET:  state_d = ST_SETTLE;
      ST_SETTLE: if (wait_zero) state_d = ST_LATCH;
      ST_LATCH: begin
        uce = 1'b1;
        if (!uend && upc_full) begin
          state_d = ST_FAULT;
        end else if (!nhalt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (nhalt || step) state_d = ST_SETTLE;
      end
      ST_FAULT:  state_d = ST_SETTLE;
      default:   state_d = ST_RESET;
    endcase
  end

  assign wait_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
  assign wait_dec  = (state_q == ST_SETTLE);

  // Address fields only move on the edge that ends LATCH, using the uend of the
  // microword that is still in the control vector register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mode_r   <= MODE_RESET;
      cond_r   <= 1'b0;
      opcode_r <= '0;
      upc_r    <= '0;
    end else if (state_q == ST_LATCH) begin
      cond_r <= cond;
      if (uend) begin
        upc_r    <= '0;
        opcode_r <= opcode;
        mode_r   <= irq ? MODE_IRQ : MODE_EXEC;
      end else if (upc_full) begin
        upc_r  <= '0;
        mode_r <= MODE_FAULT;
      end else begin
        upc_r <= upc_r + UPC_BITS'(1);
      end
    end
  end

  // Control vector outputs stay disabled until the first microword is latched.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      noe_r <= 1'b1;
    end else if (state_q == ST_LATCH) begin
      noe_r <= 1'b0;
    end
  end

  assign ucs_noe = noe_r;
  assign upc     = upc_r;
  assign uaddr   = {mode_r, cond_r, opcode_r, upc_r};

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed testbench for microcode_sequencer with ROM_WAIT=3.
module tb_microcode_sequencer;

  localparam int ROM_WAIT = 3;
  localparam int UPC_BITS = 5;

  logic          clk = 1'b0;
  logic          nreset;
  logic [10:0]   opcode;
  logic          cond;
  logic          irq;
  logic          uend;
  logic          nhalt;
  logic          step;
  logic [18:0]   uaddr;
  logic          uce;
  logic          ucs_noe;
  logic          halted;
  logic [4:0]    upc;

  int   passCount  = 0;
  int   checkCount = 0;
  int   n;
  int   uceSeen;
  logic noeAtLatch;
  logic [18:0] frozenAddr;

  microcode_sequencer #(
    .ROM_WAIT(ROM_WAIT),
    .UPC_BITS(UPC_BITS)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .opcode (opcode),
    .cond   (cond),
    .irq    (irq),
    .uend   (uend),
    .nhalt  (nhalt),
    .step   (step),
    .uaddr  (uaddr),
    .uce    (uce),
    .ucs_noe(ucs_noe),
    .halted (halted),
    .upc    (upc)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic [10:0] op, input logic c, input logic i, input logic e);
    opcode = op;
    cond   = c;
    irq    = i;
    uend   = e;
  endtask

  // Tick until uce is seen (bounded); returns the number of ticks taken.
  task automatic waitUce(input string tag, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!uce && cycles < 20);
    checkOutput({tag, "_uce_seen"}, 32'(uce), 32'd1);
  endtask

  // One full microstep: wait for LATCH, then move past the edge that ends it.
  task automatic doStep(input string tag, output int cycles);
    waitUce(tag, cycles);
    noeAtLatch = ucs_noe;
    tick();
  endtask

  initial begin
    nreset = 1'b0;
    nhalt  = 1'b1;
    step   = 1'b0;
    applyStimulus(11'h000, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    checkOutput("reset_uaddr", 32'(uaddr), 32'h60000);
    checkOutput("reset_uce", 32'(uce), 32'd0);
    checkOutput("reset_noe", 32'(ucs_noe), 32'd1);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_upc", 32'(upc), 32'd0);

    // Release: uce arrives 3 cycles after leaving RESET (4 edges after release)
    nreset = 1'b1;
    doStep("first", n);
    checkOutput("first_uce_latency", 32'(n), 32'd4);
    checkOutput("noe_during_first_latch", 32'(noeAtLatch), 32'd1);
    checkOutput("noe_after_first_latch", 32'(ucs_noe), 32'd0);
    checkOutput("first_step_uaddr", 32'(uaddr), 32'h60001);

    // Instruction start with opcode 2A5
    applyStimulus(11'h2A5, 1'b1, 1'b0, 1'b1);
    doStep("op2a5", n);
    checkOutput("op2a5_period", 32'(n), 32'd3);
    checkOutput("op2a5_uaddr", 32'(uaddr), 32'({2'b00, 1'b1, 11'h2A5, 5'd0}));

    // Mid-instruction opcode/irq changes must be ignored
    applyStimulus(11'h7FF, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      doStep("incr", n);
      checkOutput("incr_period", 32'(n), 32'd3);
      checkOutput("incr_upc", 32'(upc), 32'(k));
    end
    checkOutput("upc4_uaddr", 32'(uaddr), 32'({2'b00, 1'b0, 11'h2A5, 5'd4}));

    // Instruction end with irq pending
    applyStimulus(11'h13C, 1'b0, 1'b1, 1'b1);
    doStep("irq", n);
    checkOutput("irq_uaddr", 32'(uaddr), 32'({2'b01, 1'b0, 11'h13C, 5'd0}));
    applyStimulus(11'h13C, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      irq = k[0];
      doStep("irq_mid", n);
    end
    checkOutput("irq_mid_uaddr", 32'(uaddr), 32'({2'b01, 1'b0, 11'h13C, 5'd6}));

    // Halt: the step in flight completes and the machine stops at upc=7
    irq   = 1'b0;
    nhalt = 1'b0;
    doStep("halt", n);
    checkOutput("halt_halted", 32'(halted), 32'd1);
    checkOutput("halt_upc", 32'(upc), 32'd7);
    frozenAddr = 19'({2'b01, 1'b0, 11'h13C, 5'd7});
    uceSeen = 0;
    repeat (5) begin
      tick();
      if (uce) uceSeen++;
    end
    checkOutput("halt_idle_uce", 32'(uceSeen), 32'd0);
    checkOutput("halt_frozen_uaddr", 32'(uaddr), 32'(frozenAddr));

    // Three single-step pulses
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      waitUce("step", n);
      checkOutput("step_latency", 32'(n + 1), 32'(ROM_WAIT + 1));
      tick();
      checkOutput("step_rehalt", 32'(halted), 32'd1);
    end
    uceSeen = 0;
    repeat (6) begin
      tick();
      if (uce) uceSeen++;
    end
    checkOutput("post_step_uce", 32'(uceSeen), 32'd0);
    checkOutput("post_step_upc", 32'(upc), 32'd10);

    // Resume
    nhalt = 1'b1;
    tick();
    checkOutput("resume_halted", 32'(halted), 32'd0);
    doStep("resume", n);
    checkOutput("resume_period", 32'(n), 32'd3);
    checkOutput("resume_upc", 32'(upc), 32'd11);

    // Run upc up to all-ones with uend held low
    for (int k = 0; k < 40 && upc != 5'd31; k++) begin
      doStep("run", n);
    end
    checkOutput("run_upc31", 32'(upc), 32'd31);
    doStep("wrap", n);
    checkOutput("wrap_uaddr", 32'(uaddr), 32'({2'b10, 1'b0, 11'h13C, 5'd0}));

    // Fault microcode ends its instruction; the FAULT cycle adds one tick
    applyStimulus(11'h0A0, 1'b0, 1'b0, 1'b1);
    doStep("fault_exit", n);
    checkOutput("fault_exit_period", 32'(n), 32'd4);
    checkOutput("fault_exit_uaddr", 32'(uaddr), 32'({2'b00, 1'b0, 11'h0A0, 5'd0}));

    // Reset in the middle of SETTLE
    uend = 1'b0;
    tick();
    nreset = 1'b0;
    #1;
    checkOutput("midreset_uaddr", 32'(uaddr), 32'h60000);
    checkOutput("midreset_uce", 32'(uce), 32'd0);
    checkOutput("midreset_noe", 32'(ucs_noe), 32'd1);
    checkOutput("midreset_halted", 32'(halted), 32'd0);
    checkOutput("midreset_upc", 32'(upc), 32'd0);
    uceSeen = 0;
    repeat (4) begin
      tick();
      if (uce) uceSeen++;
    end
    checkOutput("reset_hold_uce", 32'(uceSeen), 32'd0);
    nreset = 1'b1;
    doStep("rerelease", n);
    checkOutput("rerelease_latency", 32'(n), 32'd4);
    checkOutput("rerelease_uaddr", 32'(uaddr), 32'h60001);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
